// File: rtl/col_scan_if.sv
// Keypad column-scan bus: row-decoder inputs toward the scan driver and the
// column drive / accepted-key outputs back out.
// master: row decoder / consumer side. slave: col_scan_driver side.
interface col_scan_if;
    logic       key_pressed;
    logic [3:0] key_value;
    logic       is_sign_key;
    logic [3:0] col_shift_reg;
    logic [3:0] key_code;
    logic       key_sign;
    logic       key_valid;
    logic       busy;

    modport master (
        output key_pressed, key_value, is_sign_key,
        input  col_shift_reg, key_code, key_sign, key_valid, busy
    );

    modport slave (
        input  key_pressed, key_value, is_sign_key,
        output col_shift_reg, key_code, key_sign, key_valid, busy
    );
endinterface

// File: rtl/col_scan_driver.sv
// Keypad column scanner with press/release debounce.
// The column drive rotates one-hot while idle, freezes on a detected key,
// debounces the press, emits one key_valid per accepted press and waits for a
// debounced release before scanning again.
// Optional feature: define COL_SCAN_AUTOREPEAT_EN to re-pulse key_valid every
// REPEAT_CYCLES cycles while a key is held.
module col_scan_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic     slow_clk,
    input  logic     rst,
    col_scan_if.slave bus
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Reject out-of-range parameters at elaboration.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_param
        $error("col_scan_driver: parameter out of range");
    end

    state_t     state_reg;
    logic [3:0] col_reg;
    logic [3:0] cand_value_reg;
    logic       cand_sign_reg;
    logic [7:0] cnt_reg;
    logic [3:0] key_code_reg;
    logic       key_sign_reg;
    logic       key_valid_reg;

    logic [3:0] col_rot;
    logic [7:0] cnt_inc;
    logic       cnt_done;
    logic       cand_match;

    // Right rotation of the one-hot column: bit gi takes bit gi+1, bit 3 takes bit 0.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign col_rot[gi] = col_reg[(gi + 1) % 4];
    end

    // Saturating increment; the count never wraps back to zero.
    assign cnt_inc    = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
    // True on the edge where this sample brings the stable run to DEBOUNCE_CYCLES.
    assign cnt_done   = ({1'b0, cnt_reg} + 9'd1) >= 9'(DEBOUNCE_CYCLES);
    assign cand_match = (bus.key_value == cand_value_reg) &&
                        (bus.is_sign_key == cand_sign_reg);

`ifdef COL_SCAN_AUTOREPEAT_EN
    logic [15:0] rpt_reg;
    logic        rpt_done;

    // Fires on the REPEAT_CYCLES-th held cycle since the last pulse or restart.
    assign rpt_done = ({1'b0, rpt_reg} + 17'd1) >= 17'(REPEAT_CYCLES);
`endif

    // Scan/debounce state machine with all outputs registered.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_reg      <= SCAN;
            col_reg        <= 4'b1000;
            cand_value_reg <= 4'd0;
            cand_sign_reg  <= 1'b0;
            cnt_reg        <= 8'd0;
            key_code_reg   <= 4'd0;
            key_sign_reg   <= 1'b0;
            key_valid_reg  <= 1'b0;
`ifdef COL_SCAN_AUTOREPEAT_EN
            rpt_reg        <= 16'd0;
`endif
        end else begin
            key_valid_reg <= 1'b0;
            case (state_reg)
                SCAN: begin
                    if (bus.key_pressed) begin
                        // Column stays on the row that reported the key.
                        cand_value_reg <= bus.key_value;
                        cand_sign_reg  <= bus.is_sign_key;
                        cnt_reg        <= 8'd1;
                        state_reg      <= DEBOUNCE;
                    end else begin
                        col_reg <= col_rot;
                    end
                end
                DEBOUNCE: begin
                    if (!bus.key_pressed || !cand_match) begin
                        // Bounce or changed code: drop the candidate silently.
                        state_reg <= SCAN;
                    end else begin
                        cnt_reg <= cnt_inc;
                        if (cnt_done) begin
                            key_code_reg  <= cand_value_reg;
                            key_sign_reg  <= cand_sign_reg;
                            key_valid_reg <= 1'b1;
                            state_reg     <= HELD;
`ifdef COL_SCAN_AUTOREPEAT_EN
                            rpt_reg       <= 16'd0;
`endif
                        end
                    end
                end
                HELD: begin
                    if (!bus.key_pressed) begin
                        cnt_reg   <= 8'd1;
                        state_reg <= RELEASE;
`ifdef COL_SCAN_AUTOREPEAT_EN
                        rpt_reg   <= 16'd0;
`endif
                    end
`ifdef COL_SCAN_AUTOREPEAT_EN
                    else if (rpt_done) begin
                        rpt_reg       <= 16'd0;
                        key_valid_reg <= 1'b1;
                    end else begin
                        rpt_reg <= rpt_reg + 16'd1;
                    end
`endif
                end
                RELEASE: begin
                    if (bus.key_pressed) begin
                        // Release glitch: same key still down, no new event.
                        state_reg <= HELD;
`ifdef COL_SCAN_AUTOREPEAT_EN
                        rpt_reg   <= 16'd0;
`endif
                    end else begin
                        cnt_reg <= cnt_inc;
                        if (cnt_done) begin
                            state_reg <= SCAN;
                        end
                    end
                end
                default: begin
                    state_reg <= SCAN;
                end
            endcase
        end
    end

    assign bus.col_shift_reg = col_reg;
    assign bus.key_code      = key_code_reg;
    assign bus.key_sign      = key_sign_reg;
    assign bus.key_valid     = key_valid_reg;
    assign bus.busy          = (state_reg != SCAN);

endmodule

// File: tb/tb_col_scan_driver.sv
// Self-checking bench for col_scan_driver. Stimulus is a list of press
// episodes (press length, optional release glitch, idle tail); expected
// outputs per cycle are derived from the episode timing rules.
module tb_col_scan_driver;

    localparam int DC = 4;
    localparam int RC = 8;

    logic slow_clk = 1'b0;
    logic rst;

    col_scan_if bus ();

    col_scan_driver #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_CYCLES  (RC)
    ) dut (
        .slow_clk(slow_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 slow_clk = ~slow_clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] e_col;
    logic [3:0] e_code;
    logic       e_sign;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, compare every output.
    task automatic cycle(input logic p, input logic [3:0] v, input logic s,
                         input logic frz, input logic exp_valid, input logic exp_busy);
        bus.key_pressed = p;
        bus.key_value   = v;
        bus.is_sign_key = s;
        @(posedge slow_clk);
        #1;
        if (!frz) e_col = {e_col[0], e_col[3:1]};
        chk("col",    8'(bus.col_shift_reg), 8'(e_col));
        chk("onehot", 8'($onehot(bus.col_shift_reg)), 8'd1);
        chk("valid",  8'(bus.key_valid), 8'(exp_valid));
        chk("code",   8'(bus.key_code), 8'(e_code));
        chk("sign",   8'(bus.key_sign), 8'(e_sign));
        chk("busy",   8'(bus.busy), 8'(exp_busy));
    endtask

    // Episode: p1 pressed cycles, optional g-cycle release glitch then p2 more
    // pressed cycles, then t idle cycles. mm replaces the idle tail by one
    // pressed cycle carrying a different code (candidate mismatch).
    task automatic run_scenario(input string name, input int p1, input int g, input int p2,
                                input int t, input logic [3:0] v, input logic s, input bit mm);
        int l;
        bit acc;
        int frozen_len;
        int busy_len;
        int total;
        int hold2;
        int pulses;
        l          = (g > 0) ? p1 + g + p2 : p1;
        acc        = (p1 >= DC);
        frozen_len = acc ? l + DC : p1 + 1;
        busy_len   = acc ? l + DC - 1 : p1;
        total      = mm ? p1 + 1 : l + t;
        hold2      = p1 + g;
        pulses     = 0;
        for (int r = 0; r < total; r++) begin
            logic       p;
            logic [3:0] vv;
            logic       ev;
            p  = (r < p1) || (g > 0 && r >= hold2 && r < l) || (mm && r == p1);
            vv = (mm && r == p1) ? ~v : v;
            ev = acc && (r == DC - 1);
`ifdef COL_SCAN_AUTOREPEAT_EN
            if (acc && r > DC - 1 && r < p1 && ((r - (DC - 1)) % RC) == 0) ev = 1'b1;
            if (acc && g > 0 && r > hold2 && r < l && ((r - hold2) % RC) == 0) ev = 1'b1;
`endif
            if (ev) begin
                e_code = v;
                e_sign = s;
                pulses++;
            end
            cycle(p, vv, s, r < frozen_len, ev, r < busy_len);
        end
        $display("episode %s: press=%0d glitch=%0d repress=%0d idle=%0d key=%h sign=%0d pulses=%0d",
                 name, p1, g, p2, t, v, s, pulses);
    endtask

    initial begin
        rst             = 1'b1;
        bus.key_pressed = 1'b0;
        bus.key_value   = 4'd0;
        bus.is_sign_key = 1'b0;
        e_col           = 4'b1000;
        e_code          = 4'd0;
        e_sign          = 1'b0;

        // Reset values while rst is held.
        #1;
        chk("rst_col",   8'(bus.col_shift_reg), 8'h8);
        chk("rst_code",  8'(bus.key_code), 8'h0);
        chk("rst_sign",  8'(bus.key_sign), 8'h0);
        chk("rst_valid", 8'(bus.key_valid), 8'h0);
        chk("rst_busy",  8'(bus.busy), 8'h0);
        @(posedge slow_clk);
        @(posedge slow_clk);
        #1;
        chk("rst_hold_col", 8'(bus.col_shift_reg), 8'h8);
        rst = 1'b0;
        $display("reset released");

        // Idle scan: rotation starts on the first edge.
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("idle scan 8 cycles");

        run_scenario("press_5",      6, 0, 0, DC + 2, 4'h5, 1'b0, 1'b0);
        run_scenario("sign_A",       5, 0, 0, DC + 1, 4'hA, 1'b1, 1'b0);
        run_scenario("bounce_1",     1, 0, 0, DC + 1, 4'h7, 1'b0, 1'b0);
        run_scenario("bounce_2",     2, 0, 0, DC + 3, 4'h3, 1'b1, 1'b0);
        run_scenario("rel_glitch",   6, 2, 3, DC + 2, 4'hE, 1'b0, 1'b0);
        run_scenario("mismatch",     2, 0, 0, 0,      4'h6, 1'b0, 1'b1);
        run_scenario("after_mm",     5, 0, 0, DC + 1, 4'h9, 1'b0, 1'b0);
        run_scenario("long_hold",   20, 0, 0, DC + 2, 4'h1, 1'b1, 1'b0);

        for (int k = 0; k < 24; k++) begin
            int         p1;
            int         g;
            int         p2;
            int         t;
            logic [3:0] v;
            logic       s;
`ifdef COL_SCAN_AUTOREPEAT_EN
            p1 = int'($urandom_range(1, 24));
`else
            p1 = int'($urandom_range(1, 10));
`endif
            g  = 0;
            p2 = 0;
            if ($urandom_range(0, 3) == 0) begin
                if (p1 < DC) p1 = DC;
                g  = int'($urandom_range(1, DC - 1));
                p2 = int'($urandom_range(1, 12));
            end
            t = int'($urandom_range(DC, DC + 4));
            v = 4'($urandom_range(0, 15));
            s = 1'($urandom_range(0, 1));
            run_scenario("random", p1, g, p2, t, v, s, 1'b0);
        end

        run_scenario("final_C", 4, 0, 0, DC, 4'hC, 1'b1, 1'b0);

        // Asynchronous reset in DEBOUNCE at count 2.
        bus.key_pressed = 1'b1;
        bus.key_value   = 4'h3;
        bus.is_sign_key = 1'b0;
        @(posedge slow_clk);
        #1;
        chk("det_busy", 8'(bus.busy), 8'h1);
        chk("det_col",  8'(bus.col_shift_reg), 8'(e_col));
        @(posedge slow_clk);
        #1;
        chk("cnt2_busy",  8'(bus.busy), 8'h1);
        chk("cnt2_valid", 8'(bus.key_valid), 8'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_col",   8'(bus.col_shift_reg), 8'h8);
        chk("arst_code",  8'(bus.key_code), 8'h0);
        chk("arst_sign",  8'(bus.key_sign), 8'h0);
        chk("arst_valid", 8'(bus.key_valid), 8'h0);
        chk("arst_busy",  8'(bus.busy), 8'h0);
        bus.key_pressed = 1'b0;
        @(posedge slow_clk);
        #1;
        chk("arst_hold_valid", 8'(bus.key_valid), 8'h0);
        chk("arst_hold_col",   8'(bus.col_shift_reg), 8'h8);
        #2;
        rst = 1'b0;
        @(posedge slow_clk);
        #1;
        chk("post_rst_col",  8'(bus.col_shift_reg), 8'h4);
        chk("post_rst_busy", 8'(bus.busy), 8'h0);
        $display("async reset in debounce");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
